// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the button conditioner.
// Defaults assume a 27 MHz clock.
package btn_cond_pkg;

  localparam int unsigned DEF_DB_CYCLES     = 270000;
  localparam int unsigned DEF_REPEAT_DELAY  = 13500000;
  localparam int unsigned DEF_REPEAT_PERIOD = 2700000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Switch inputs and conditioned strobe/level outputs of the button conditioner.
interface button_conditioner_if;
  logic i_btn_sed;
  logic i_btn_cnt;
  logic o_sed_pulse;
  logic o_cnt_pulse;
  logic o_sed_level;
  logic o_cnt_level;

  modport master (
    output i_btn_sed, i_btn_cnt,
    input  o_sed_pulse, o_cnt_pulse, o_sed_level, o_cnt_level
  );

  modport slave (
    input  i_btn_sed, i_btn_cnt,
    output o_sed_pulse, o_cnt_pulse, o_sed_level, o_cnt_level
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One switch channel: polarity normalise, 2-flop sync, debounce, press strobe.
// o_level_nxt_c is the value the stable level takes at the next edge.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DEF_DB_CYCLES,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse,
  output logic o_level_nxt_c
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES);

  logic            w_norm;
  logic            w_accept;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_pulse;
  logic [DB_W-1:0] r_cnt;

  assign w_norm        = BTN_ACTIVE_LOW ? ~i_btn : i_btn;
  assign w_accept      = (r_sync2 != r_stable) && (r_cnt == DB_W'(DB_CYCLES - 1));
  assign o_level_nxt_c = w_accept ? r_sync2 : r_stable;
  assign o_level       = r_stable;
  assign o_pulse       = r_pulse;

  // Counter runs only while the synchronised input disagrees with the stable level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= w_norm;
      r_sync2  <= r_sync1;
      r_stable <= o_level_nxt_c;
      r_pulse  <= w_accept & r_sync2;
      if ((r_sync2 == r_stable) || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the send and count switches into one-cycle strobes and levels;
// the count channel adds hold-to-auto-repeat.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = DEF_DB_CYCLES,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter bit          REPEAT_EN      = 1'b1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  button_conditioner_if.slave bus
);

  localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  logic              w_sed_level;
  logic              w_sed_pulse;
  logic              w_sed_level_nxt;
  logic              w_cnt_level;
  logic              w_cnt_pulse;
  logic              w_cnt_level_nxt;
  logic              w_unused;
  rep_state_e        r_state;
  rep_state_e        w_state_nxt;
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic              r_rep_pulse;
  logic              w_rep_nxt;

  btn_debounce_ch #(.DB_CYCLES(DB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_sed (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_btn        (bus.i_btn_sed),
    .o_level      (w_sed_level),
    .o_pulse      (w_sed_pulse),
    .o_level_nxt_c(w_sed_level_nxt)
  );

  btn_debounce_ch #(.DB_CYCLES(DB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_cnt (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_btn        (bus.i_btn_cnt),
    .o_level      (w_cnt_level),
    .o_pulse      (w_cnt_pulse),
    .o_level_nxt_c(w_cnt_level_nxt)
  );

  assign w_unused = w_sed_level_nxt;

  // Repeat state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_rcnt      <= '0;
      r_rep_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_rep_pulse <= w_rep_nxt;
    end
  end

  // Decisions use the next stable level so DELAY starts with the press strobe
  // and a release edge can never carry a repeat strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep_nxt   = 1'b0;
    if (!w_cnt_level_nxt || !REPEAT_EN) begin
      w_state_nxt = ST_IDLE;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_cnt_level) begin
            w_state_nxt = ST_DELAY;
            w_rcnt_nxt  = '0;
          end
        end
        ST_DELAY: begin
          if (r_rcnt == RCNT_W'(REPEAT_DELAY - 1)) begin
            w_rep_nxt   = 1'b1;
            w_rcnt_nxt  = '0;
            w_state_nxt = ST_REPEAT;
          end else begin
            w_rcnt_nxt = r_rcnt + RCNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (r_rcnt == RCNT_W'(REPEAT_PERIOD - 1)) begin
            w_rep_nxt  = 1'b1;
            w_rcnt_nxt = '0;
          end else begin
            w_rcnt_nxt = r_rcnt + RCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.o_sed_pulse = w_sed_pulse;
  assign bus.o_sed_level = w_sed_level;
  assign bus.o_cnt_pulse = w_cnt_pulse | r_rep_pulse;
  assign bus.o_cnt_level = w_cnt_level;

endmodule
